// File: rtl/mem_func_pkg.sv
// mem_func_pkg: memory function codes, MEM FSM states and byte-enable helper.
package mem_func_pkg;
    localparam logic [2:0] BS = 3'd0, BU = 3'd1, HS = 3'd2, HU = 3'd3;
    localparam logic [2:0] WD = 3'd4, WL = 3'd5, WR = 3'd6, WC = 3'd7;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    function automatic logic [3:0] byte_en(input logic [2:0] f, input logic [1:0] a, input logic we);
        logic [3:0] be;
        be = 4'b1111;
        if (we) begin
            if (f == BS || f == BU) be = 4'b0001 << a;
            else if (f == HS || f == HU) be = a[1] ? 4'b1100 : 4'b0011;
            else if (f == WL) be = 4'b1100;
            else if (f == WR) be = 4'b0011;
        end
        return be;
    endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane formatting, byte enables, load alignment and misalign check.
module mem_align
    import mem_func_pkg::*;
(
    input  logic [2:0]  func,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_al,
    output logic        misaligned
);
    logic is_b, is_h;

    assign is_b = func == BS || func == BU;
    assign is_h = func == HS || func == HU;
    assign be = byte_en(func, addr, we);
    assign wdata = is_b ? {4{rt[7:0]}} : is_h ? {2{rt[15:0]}} : rt;
    assign rdata_al = is_b ? rdata >> {addr, 3'b000} : is_h ? rdata >> {addr[1], 4'b0000} : rdata;
    // WC is a load-only word access; a store with WC is rejected like a misalignment
    assign misaligned = (is_h & addr[0]) | ((func == WD || func == WC) & |addr) | (func == WC & we);
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with req/ack data-memory port, timeout and MEM/WB register.
module mem_stage
    import mem_func_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        ex_valid,
    input  logic [31:0] ALUData,
    input  logic [31:0] RtData,
    input  logic [2:0]  Memfunc,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_ALUData,
    output logic [31:0] wb_RtData,
    output logic [31:0] wb_MemData,
    output logic [2:0]  wb_Memfunc,
    output logic        wb_MemtoReg,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_WriteReg,
    output logic        addr_error,
    output logic        bus_error
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   l_alu, l_rt;
    logic [2:0]    l_func;
    logic          l_we, l_mtr, l_rw;
    logic [4:0]    l_wr;
    logic          wb_rw;

    logic          idle, mem_op, legal, timeout, done, alu_op, cap;
    logic [31:0]   c_alu, c_rt;
    logic [2:0]    c_func;
    logic          c_we, c_mtr, c_rw;
    logic [4:0]    c_wr;
    logic [3:0]    al_be;
    logic [31:0]   al_wdata, rdata_al;
    logic          misaligned;

    // in WAIT every request field comes from the latched copy so the bus stays stable
    assign idle   = state == IDLE;
    assign c_alu  = idle ? ALUData : l_alu;
    assign c_rt   = idle ? RtData : l_rt;
    assign c_func = idle ? Memfunc : l_func;
    assign c_we   = idle ? MemWrite : l_we;
    assign c_mtr  = idle ? MemtoReg : l_mtr;
    assign c_rw   = idle ? RegWrite : l_rw;
    assign c_wr   = idle ? WriteReg : l_wr;

    mem_align u_align (
        .func(c_func), .addr(c_alu[1:0]), .we(c_we), .rt(c_rt), .rdata(dmem_rdata),
        .be(al_be), .wdata(al_wdata), .rdata_al(rdata_al), .misaligned(misaligned)
    );

    assign mem_op  = ex_valid & (MemRead | MemWrite);
    assign legal   = mem_op & ~misaligned;
    assign timeout = ~idle & ~dmem_ack & (cnt == CW'(TIMEOUT - 1));
    assign done    = (~idle | legal) & dmem_ack;
    assign alu_op  = idle & ex_valid & ~mem_op;
    assign cap     = done | alu_op;

    assign dmem_req    = nrst & (~idle | legal);
    assign dmem_we     = dmem_req & c_we;
    assign dmem_addr   = dmem_req ? {c_alu[31:2], 2'b00} : '0;
    assign dmem_be     = dmem_req ? al_be : '0;
    assign dmem_wdata  = dmem_req ? al_wdata : '0;
    assign stall       = nrst & ((idle & legal & ~dmem_ack) | (~idle & ~dmem_ack & ~timeout));
    assign wb_RegWrite = wb_rw & wb_valid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt <= '0;
            {l_alu, l_rt, l_func, l_we, l_mtr, l_rw, l_wr} <= '0;
            {wb_valid, wb_ALUData, wb_RtData, wb_MemData, wb_Memfunc, wb_MemtoReg, wb_rw, wb_WriteReg} <= '0;
            addr_error <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            addr_error <= idle & mem_op & misaligned;
            bus_error <= timeout;
            wb_valid <= cap;
            if (cap) begin
                wb_ALUData <= c_alu;
                wb_RtData <= c_rt;
                wb_MemData <= (done & ~c_we) ? rdata_al : '0;
                wb_Memfunc <= c_func;
                wb_MemtoReg <= c_mtr;
                wb_rw <= c_rw;
                wb_WriteReg <= c_wr;
            end
            // cnt counts cycles the request has been on the bus, including the IDLE issue cycle
            if (idle & legal & ~dmem_ack) begin
                state <= WAIT;
                cnt <= CW'(1);
                l_alu <= ALUData;
                l_rt <= RtData;
                l_func <= Memfunc;
                l_we <= MemWrite;
                l_mtr <= MemtoReg;
                l_rw <= RegWrite;
                l_wr <= WriteReg;
            end else if (~idle & (dmem_ack | timeout)) begin
                state <= IDLE;
                cnt <= '0;
            end else if (~idle) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage with TIMEOUT=4.
module tb_mem_stage;
    import mem_func_pkg::*;

    typedef struct packed {
        logic [31:0] alu, rt, mem;
        logic [2:0]  func;
        logic        mtr, rw;
        logic [4:0]  wr;
        logic        mchk;
    } exp_t;

    logic clk = 1'b0, nrst;
    logic ex_valid, MemRead, MemWrite, MemtoReg, RegWrite, dmem_ack;
    logic [31:0] ALUData, RtData, dmem_rdata;
    logic [2:0] Memfunc;
    logic [4:0] WriteReg;
    logic dmem_req, dmem_we, stall, wb_valid, wb_MemtoReg, wb_RegWrite, addr_error, bus_error;
    logic [31:0] dmem_addr, dmem_wdata, wb_ALUData, wb_RtData, wb_MemData;
    logic [3:0] dmem_be;
    logic [2:0] wb_Memfunc;
    logic [4:0] wb_WriteReg;

    int checks = 0, errors = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .nrst(nrst), .ex_valid(ex_valid), .ALUData(ALUData), .RtData(RtData),
        .Memfunc(Memfunc), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall), .wb_valid(wb_valid),
        .wb_ALUData(wb_ALUData), .wb_RtData(wb_RtData), .wb_MemData(wb_MemData),
        .wb_Memfunc(wb_Memfunc), .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
        .wb_WriteReg(wb_WriteReg), .addr_error(addr_error), .bus_error(bus_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [31:0] alu, input logic [31:0] rt, input logic [2:0] f,
                         input logic rd, input logic wr, input logic mtr, input logic rw, input logic [4:0] wreg);
        ex_valid = ev; ALUData = alu; RtData = rt; Memfunc = f;
        MemRead = rd; MemWrite = wr; MemtoReg = mtr; RegWrite = rw; WriteReg = wreg;
    endtask

    task automatic nop();
        drive(1'b0, 32'h0, 32'h0, BS, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] mem, input logic [2:0] f,
                        input logic mtr, input logic rw, input logic [4:0] wr, input logic mchk);
        exp_t e;
        e.alu = alu; e.rt = rt; e.mem = mem; e.func = f; e.mtr = mtr; e.rw = rw; e.wr = wr; e.mchk = mchk;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (nrst && wb_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_valid=1 expected no write-back");
            end else begin
                mon_e = q.pop_front();
                chk("wb_ALUData", wb_ALUData, mon_e.alu);
                chk("wb_RtData", wb_RtData, mon_e.rt);
                chk("wb_Memfunc", 32'(wb_Memfunc), 32'(mon_e.func));
                chk("wb_MemtoReg", 32'(wb_MemtoReg), 32'(mon_e.mtr));
                chk("wb_RegWrite", 32'(wb_RegWrite), 32'(mon_e.rw));
                chk("wb_WriteReg", 32'(wb_WriteReg), 32'(mon_e.wr));
                if (mon_e.mchk) chk("wb_MemData", wb_MemData, mon_e.mem);
            end
        end
    end

    initial begin
        nrst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        nop();
        #1 nrst = 1'b0;
        #2;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_alu", wb_ALUData, 0);
        chk("rst_addr_error", 32'(addr_error), 0);
        chk("rst_bus_error", 32'(bus_error), 0);
        step();
        nrst = 1'b1;

        // zero-wait word load
        step();
        drive(1'b1, 32'h100, 32'h0, WD, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        push(32'h100, 32'h0, 32'hDEADBEEF, WD, 1'b1, 1'b1, 5'd5, 1'b1);
        #3;
        chk("t1_req", 32'(dmem_req), 1);
        chk("t1_we", 32'(dmem_we), 0);
        chk("t1_addr", dmem_addr, 32'h100);
        chk("t1_be", 32'(dmem_be), 32'hF);
        chk("t1_stall", 32'(stall), 0);
        step();
        nop(); dmem_ack = 1'b0;
        #3;
        chk("t1_req_drop", 32'(dmem_req), 0);
        chk("t1_wb_valid", 32'(wb_valid), 1);

        // byte store with wait states; ack lands on the cycle the timeout would fire
        step();
        drive(1'b1, 32'h203, 32'hA5, BS, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        #3;
        chk("t2_req", 32'(dmem_req), 1);
        chk("t2_we", 32'(dmem_we), 1);
        chk("t2_addr", dmem_addr, 32'h200);
        chk("t2_be", 32'(dmem_be), 32'h8);
        chk("t2_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("t2_stall", 32'(stall), 1);
        for (int i = 0; i < 2; i++) begin
            step();
            drive(1'b1, 32'hFFFFFFFC, 32'h11111111, WD, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
            #3;
            chk("t2_hold_addr", dmem_addr, 32'h200);
            chk("t2_hold_be", 32'(dmem_be), 32'h8);
            chk("t2_hold_wdata", dmem_wdata, 32'hA5A5A5A5);
            chk("t2_hold_we", 32'(dmem_we), 1);
            chk("t2_hold_stall", 32'(stall), 1);
            chk("t2_bubble", 32'(wb_valid), 0);
        end
        step();
        dmem_ack = 1'b1;
        push(32'h203, 32'hA5, 32'h0, BS, 1'b0, 1'b0, 5'd0, 1'b0);
        #3;
        chk("t2_ack_stall", 32'(stall), 0);
        chk("t2_ack_req", 32'(dmem_req), 1);
        chk("t2_ack_addr", dmem_addr, 32'h200);
        step();
        nop(); dmem_ack = 1'b0;
        #3;
        chk("t2_wb_valid", 32'(wb_valid), 1);
        chk("t2_no_bus_error", 32'(bus_error), 0);

        // halfword and byte loads, halfword and WL stores, all zero-wait
        step();
        drive(1'b1, 32'h102, 32'h0, HU, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        dmem_ack = 1'b1; dmem_rdata = 32'h1234ABCD;
        push(32'h102, 32'h0, 32'h00001234, HU, 1'b1, 1'b1, 5'd3, 1'b1);
        #3;
        chk("t3_addr", dmem_addr, 32'h100);
        chk("t3_be", 32'(dmem_be), 32'hF);
        chk("t3_stall", 32'(stall), 0);
        step();
        drive(1'b1, 32'h101, 32'h0, BU, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
        push(32'h101, 32'h0, 32'h001234AB, BU, 1'b1, 1'b1, 5'd4, 1'b1);
        step();
        drive(1'b1, 32'h102, 32'h1234BEEF, HS, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        push(32'h102, 32'h1234BEEF, 32'h0, HS, 1'b0, 1'b0, 5'd0, 1'b0);
        #3;
        chk("t3_hs_be", 32'(dmem_be), 32'hC);
        chk("t3_hs_wdata", dmem_wdata, 32'hBEEFBEEF);
        chk("t3_hs_we", 32'(dmem_we), 1);
        step();
        drive(1'b1, 32'h001, 32'hCAFE1234, WL, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        push(32'h001, 32'hCAFE1234, 32'h0, WL, 1'b0, 1'b0, 5'd0, 1'b0);
        #3;
        chk("t3_wl_req", 32'(dmem_req), 1);
        chk("t3_wl_addr", dmem_addr, 32'h0);
        chk("t3_wl_be", 32'(dmem_be), 32'hC);
        chk("t3_wl_wdata", 32'(dmem_wdata[31:16]), 32'hCAFE);
        step();
        nop(); dmem_ack = 1'b0;

        // misaligned HS load, then illegal WC store
        step();
        drive(1'b1, 32'h101, 32'h0, HS, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
        #3;
        chk("t4_req", 32'(dmem_req), 0);
        chk("t4_stall", 32'(stall), 0);
        step();
        nop();
        #3;
        chk("t4_addr_error", 32'(addr_error), 1);
        chk("t4_wb_valid", 32'(wb_valid), 0);
        step();
        drive(1'b1, 32'h100, 32'h0, WC, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        #3;
        chk("t4_addr_error_pulse", 32'(addr_error), 0);
        chk("t4_wc_req", 32'(dmem_req), 0);
        step();
        nop();
        #3;
        chk("t4_wc_addr_error", 32'(addr_error), 1);

        // timeout: request held 4 cycles, never acknowledged
        step();
        drive(1'b1, 32'h300, 32'h0, WD, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("t5_req", 32'(dmem_req), 1);
            chk("t5_stall", 32'(stall), 1);
            step();
        end
        #3;
        chk("t5_last_req", 32'(dmem_req), 1);
        chk("t5_last_stall", 32'(stall), 0);
        step();
        nop();
        #3;
        chk("t5_bus_error", 32'(bus_error), 1);
        chk("t5_req_drop", 32'(dmem_req), 0);
        chk("t5_stall_low", 32'(stall), 0);
        chk("t5_wb_valid", 32'(wb_valid), 0);
        chk("t5_wb_regwrite", 32'(wb_RegWrite), 0);
        step();
        #3;
        chk("t5_bus_error_pulse", 32'(bus_error), 0);

        // asynchronous reset in WAIT, then an ALU op with latency 1
        step();
        drive(1'b1, 32'h400, 32'h0, WD, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
        #3;
        chk("t6_req", 32'(dmem_req), 1);
        step();
        #1 nrst = 1'b0;
        #1;
        chk("t6_rst_req", 32'(dmem_req), 0);
        chk("t6_rst_stall", 32'(stall), 0);
        chk("t6_rst_wb_valid", 32'(wb_valid), 0);
        step();
        nop();
        nrst = 1'b1;
        step();
        drive(1'b1, 32'h55, 32'h66, WD, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
        push(32'h55, 32'h66, 32'h0, WD, 1'b0, 1'b1, 5'd7, 1'b1);
        #3;
        chk("t6_alu_req", 32'(dmem_req), 0);
        chk("t6_alu_stall", 32'(stall), 0);
        step();
        nop();
        #3;
        chk("t6_wb_valid", 32'(wb_valid), 1);
        chk("t6_wb_regwrite", 32'(wb_RegWrite), 1);
        step();
        #3;
        chk("t6_wb_valid_drop", 32'(wb_valid), 0);
        chk("t6_wb_alu_hold", wb_ALUData, 32'h55);
        chk("t6_wb_regwrite_qual", 32'(wb_RegWrite), 0);

        step();
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
